// File: rtl/ecc_load_scrub_ctrl.sv
// ecc_load_scrub_ctrl
// Sits around the external DECTED load-correction stage. It issues the cache
// read for a load, waits for the corrected word and error flags, and re-reads
// on triple errors while the PC is stalled. It scrubs 1-/2-bit errors by
// writing the corrected word back, and only then returns the load response.
// Optional build macro: ECC_ERR_LOG_EN adds err_log_addr / err_log_tre, which
// record the address of the most recent erroneous load.
module ecc_load_scrub_ctrl #(
  parameter int AW        = 10,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_req,
  input  logic [AW-1:0]    ld_addr,
  output logic             ld_ready,
  output logic             cache_rd_en,
  output logic [AW-1:0]    cache_rd_addr,
  input  logic             cache_rd_valid,
  input  logic [31:0]      dec_data,
  input  logic             dec_sde,
  input  logic             dec_tre,
  output logic             ld_rsp_valid,
  output logic [31:0]      ld_rsp_data,
  output logic             ld_rsp_err,
  output logic             scrub_wr_en,
  output logic [AW-1:0]    scrub_wr_addr,
  output logic [31:0]      scrub_wr_data,
  input  logic             scrub_wr_ack,
  output logic             pc_stall,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
`ifdef ECC_ERR_LOG_EN
  ,
  output logic [AW-1:0]    err_log_addr,
  output logic             err_log_tre
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SCRUB = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [2:0]       MAX_RETRY_C = 3'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_t            state_r, state_nxt_s;
  logic              ld_ready_r, rd_en_r, rsp_valid_r, scrub_en_r, pc_stall_r;
  logic [AW-1:0]     addr_r;
  logic [31:0]       data_r;
  logic              err_r;
  logic [2:0]        retry_r;
  logic [CNT_W-1:0]  cnt_corr_r, cnt_uncorr_r;
  logic              accept_s, retry_s, uncorr_s, corr_s, clean_s;

  // Next-state decode plus one-cycle event strobes for the datapath.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    retry_s     = 1'b0;
    uncorr_s    = 1'b0;
    corr_s      = 1'b0;
    clean_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ld_req) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (cache_rd_valid) begin
          if (dec_tre) begin
            if (retry_r < MAX_RETRY_C) begin
              retry_s     = 1'b1;
              state_nxt_s = ST_READ;
            end else begin
              uncorr_s    = 1'b1;
              state_nxt_s = ST_RESP;
            end
          end else if (dec_sde) begin
            corr_s      = 1'b1;
            state_nxt_s = ST_SCRUB;
          end else begin
            clean_s     = 1'b1;
            state_nxt_s = ST_RESP;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_SCRUB: begin
        if (scrub_wr_ack) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_SCRUB;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register; control outputs are registered from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ld_ready_r  <= 1'b1;
      rd_en_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      scrub_en_r  <= 1'b0;
      pc_stall_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ld_ready_r  <= (state_nxt_s == ST_IDLE);
      rd_en_r     <= (state_nxt_s == ST_READ);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      scrub_en_r  <= (state_nxt_s == ST_SCRUB);
      pc_stall_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Address/data/retry capture and saturating error counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r       <= {AW{1'b0}};
      data_r       <= 32'h0000_0000;
      err_r        <= 1'b0;
      retry_r      <= 3'd0;
      cnt_corr_r   <= {CNT_W{1'b0}};
      cnt_uncorr_r <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        addr_r  <= ld_addr;
        retry_r <= 3'd0;
      end
      if (retry_s) begin
        retry_r <= retry_r + 3'd1;
      end
      if (uncorr_s) begin
        data_r       <= dec_data;
        err_r        <= 1'b1;
        cnt_uncorr_r <= sat_inc(cnt_uncorr_r);
      end
      if (corr_s) begin
        data_r     <= dec_data;
        err_r      <= 1'b0;
        cnt_corr_r <= sat_inc(cnt_corr_r);
      end
      if (clean_s) begin
        data_r <= dec_data;
        err_r  <= 1'b0;
      end
    end
  end

`ifdef ECC_ERR_LOG_EN
  logic [AW-1:0] log_addr_r;
  logic          log_tre_r;

  // Remember where the last correctable or uncorrectable error was seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      log_addr_r <= {AW{1'b0}};
      log_tre_r  <= 1'b0;
    end else if (corr_s || uncorr_s) begin
      log_addr_r <= addr_r;
      log_tre_r  <= uncorr_s;
    end else begin
      log_addr_r <= log_addr_r;
      log_tre_r  <= log_tre_r;
    end
  end

  assign err_log_addr = log_addr_r;
  assign err_log_tre  = log_tre_r;
`endif

  assign ld_ready      = ld_ready_r;
  assign cache_rd_en   = rd_en_r;
  assign cache_rd_addr = addr_r;
  assign ld_rsp_valid  = rsp_valid_r;
  assign ld_rsp_data   = data_r;
  assign ld_rsp_err    = err_r;
  assign scrub_wr_en   = scrub_en_r;
  assign scrub_wr_addr = addr_r;
  assign scrub_wr_data = data_r;
  assign pc_stall      = pc_stall_r;
  assign cnt_corr      = cnt_corr_r;
  assign cnt_uncorr    = cnt_uncorr_r;

endmodule

// File: doc/ecc_load_scrub_ctrl.md
Name: ecc_load_scrub_ctrl

Overview:
- Sequencer directly upstream and downstream of the DECTED load-correction stage.
- Issues cache reads for loads and forwards the raw data/parity to the correction stage, which is outside this block.
- Takes back the corrected word and error flags. Returns the load response.
- Scrubs 1-/2-bit errors by writing the corrected word back through the store-path encoder; retries on triple errors while stalling the PC.

Parameters:
- AW, 10, cache word-address width.
- MAX_RETRY, 2, re-reads attempted after a triple error before reporting it uncorrectable (1..7).
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ld_req  in  1  load request; accepted when ld_req && ld_ready
- ld_addr  in  AW  load word address
- ld_ready  out  1  high only in IDLE
- cache_rd_en  out  1  one-cycle cache read strobe
- cache_rd_addr  out  AW  read address, held from accept until response
- cache_rd_valid  in  1  cache data/parity valid at the correction stage
- dec_data  in  32  corrected_data from the correction stage
- dec_sde  in  1  single_double_error from the correction stage
- dec_tre  in  1  triple_error from the correction stage
- ld_rsp_valid  out  1  one-cycle response pulse
- ld_rsp_data  out  32  response data
- ld_rsp_err  out  1  uncorrectable error flag, qualified by ld_rsp_valid
- scrub_wr_en  out  1  write-back request, held until ack
- scrub_wr_addr  out  AW  write-back address
- scrub_wr_data  out  32  corrected word; parity is regenerated by the store-path encoder
- scrub_wr_ack  in  1  write-back accepted
- pc_stall  out  1  stall request to the PC
- cnt_corr  out  CNT_W  count of scrubbed (1-/2-bit) errors, saturating
- cnt_uncorr  out  CNT_W  count of uncorrectable loads, saturating

Behaviour:
- Reset: state=IDLE. ld_ready=1. All other outputs 0, counters 0. Address and data registers 0.
- A reset asserted mid-operation aborts everything. A pending scrub write is dropped (scrub_wr_en=0 the following cycle), and no response is issued.
- State IDLE: on accept, latch ld_addr, clear the retry count, go to READ.
- State READ: cache_rd_en=1 for exactly one cycle, then go to WAIT.
- State WAIT: wait for cache_rd_valid; there is no timeout. dec_* are sampled in the same cycle that cache_rd_valid is high.
  - dec_tre=1 (takes priority over dec_sde):
    - retry count < MAX_RETRY: increment it, go to READ.
    - otherwise: go to RESP with err=1, data=dec_data, cnt_uncorr+1.
  - else dec_sde=1: latch dec_data, go to SCRUB, cnt_corr+1.
  - else: latch dec_data, go to RESP with err=0.
- State SCRUB: scrub_wr_en=1, with addr and data held stable until the cycle scrub_wr_ack=1. Then go to RESP.
  - The response is deliberately issued after the write-back, so a back-to-back load to the same address reads scrubbed data.
- State RESP: ld_rsp_valid=1 for one cycle, then go to IDLE. Throughput is at most one load per 4 cycles.
- pc_stall=1 in every state except IDLE. It deasserts in the cycle after the RESP pulse, i.e. when the state is back in IDLE.
- Counters saturate at all-ones; there is no wrap-around.
- cache_rd_valid in IDLE, READ, SCRUB or RESP is ignored. scrub_wr_ack outside SCRUB is ignored.
- ld_req arriving while ld_ready=0 is not latched; the requester must hold it.
- Retry latency: each retry adds at least 2 cycles (READ plus WAIT).

Optional Feature:
- Macro: ECC_ERR_LOG_EN.
- When defined, add two output ports:
  - err_log_addr (AW): address of the most recent load that saw any error.
  - err_log_tre (1): 1 if that error was triple.
- Both update in the same cycle that cnt_corr or cnt_uncorr would increment (even if saturated). Reset value is 0.
- When undefined, neither port nor its registers exist, and all other behaviour is identical.

Test Plan:
- Clean load: ld_addr=0x05, rd_valid 1 cycle after READ, dec_sde=dec_tre=0, dec_data=0xDEADBEEF -> ld_rsp_valid with data 0xDEADBEEF, err=0. No scrub_wr_en. Counters unchanged. pc_stall high from accept through RESP.
- Correctable error with delayed ack: dec_sde=1, dec_data=0x12345678, scrub_wr_ack delayed 3 cycles -> scrub_wr_en held 4 cycles with addr 0x05 and data 0x12345678. Response comes after the ack with err=0. cnt_corr=1.
- Triple error, then clean: dec_tre=1 on the 1st read, clean on the 2nd -> exactly two cache_rd_en pulses. Response err=0. Both counters 0.
- Persistent triple error, MAX_RETRY=2 -> three cache_rd_en pulses. ld_rsp_err=1. cnt_uncorr=1. No scrub write.
- Saturation: force 2^CNT_W+3 correctable loads (or use CNT_W=2 with 5 loads) -> cnt_corr stops at all-ones.
- Reset mid-SCRUB: rst while scrub_wr_en=1 -> next cycle scrub_wr_en=0, pc_stall=0, ld_ready=1. No ld_rsp_valid. With ECC_ERR_LOG_EN defined, err_log_addr=0.
